// File: rtl/spram_pkg.sv
// spram_pkg: shared types for spram_modes (read-during-write modes, clear FSM states).
package spram_pkg;
   typedef enum logic [1:0] {
      MODE_WRITE_FIRST = 2'd0,
      MODE_READ_FIRST  = 2'd1,
      MODE_NO_CHANGE   = 2'd2
   } rw_mode_e;
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;
endpackage

// File: rtl/spram_modes_if.sv
// spram_modes_if: access/clear bus of spram_modes; master drives requests, slave is the RAM.
interface spram_modes_if #(
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8,
   parameter int ADDR_W = 5
);
   localparam int NB = DATA_W / BYTE_W;
   logic              en;
   logic              we;
   logic [NB-1:0]     be;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic              clr;
   logic [DATA_W-1:0] dout;
   logic              rd_valid;
   logic              busy;
   modport master (output en, we, be, addr, din, clr, input dout, rd_valid, busy);
   modport slave  (input en, we, be, addr, din, clr, output dout, rd_valid, busy);
endinterface

// File: rtl/spram_clear_fsm.sv
// spram_clear_fsm: walks every address once after reset or a clr request,
// presenting a write strobe and address for the RAM's clear value.
module spram_clear_fsm import spram_pkg::*; #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   output logic              busy_o,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_addr_o
);
   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      if (state_q == CLEAR) begin
         clr_addr_d = clr_addr_q + 1'b1;
         if (&clr_addr_q) state_d = IDLE;
      end else if (clr_i) begin
         state_d    = CLEAR;
         clr_addr_d = '0;
      end
   end
   // The array must stay untouched while rst is held, even though busy is already up.
   assign busy_o     = state_q == CLEAR;
   assign clr_we_o   = busy_o && !rst;
   assign clr_addr_o = clr_addr_q;
endmodule

// File: rtl/spram_modes.sv
// spram_modes: single-port RAM with byte enables, compile-time read-during-write mode
// and a hardware clear engine. Define SPRAM_OUTREG_EN for an extra dout/rd_valid stage.
module spram_modes import spram_pkg::*; #(
   parameter int               DATA_W    = 32,
   parameter int               BYTE_W    = 8,
   parameter int               ADDR_W    = 5,
   parameter rw_mode_e         MODE      = MODE_WRITE_FIRST,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input logic          clk,
   input logic          rst,
   spram_modes_if.slave bus
);
   localparam int NB    = DATA_W / BYTE_W;
   localparam int DEPTH = 2 ** ADDR_W;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              busy, clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              acc, wr, rd_valid_d, rd_valid_q;
   logic [DATA_W-1:0] old_word, new_word, dout_d, dout_q;
   spram_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (bus.clr),
      .busy_o     (busy),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );
   // clr wins over a same-cycle access; be=0 makes a write behave as a plain read.
   always_comb begin
      acc      = bus.en && !busy && !bus.clr;
      wr       = acc && bus.we && |bus.be;
      old_word = mem_q[bus.addr];
      new_word = old_word;
      for (int i = 0; i < NB; i++)
         if (wr && bus.be[i]) new_word[i*BYTE_W +: BYTE_W] = bus.din[i*BYTE_W +: BYTE_W];
      rd_valid_d = acc && (MODE != MODE_NO_CHANGE || !wr);
      dout_d     = !rd_valid_d ? dout_q : MODE == MODE_READ_FIRST ? old_word : new_word;
   end
   always_ff @(posedge clk) begin
      if (clr_we) mem_q[clr_addr] <= CLEAR_VAL;
      else if (wr) mem_q[bus.addr] <= new_word;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         dout_q     <= dout_d;
         rd_valid_q <= rd_valid_d;
      end
   end
`ifdef SPRAM_OUTREG_EN
   logic [DATA_W-1:0] dout2_q;
   logic              rd_valid2_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         dout2_q     <= '0;
         rd_valid2_q <= 1'b0;
      end else begin
         dout2_q     <= dout_q;
         rd_valid2_q <= rd_valid_q;
      end
   end
   assign bus.dout     = dout2_q;
   assign bus.rd_valid = rd_valid2_q;
`else
   assign bus.dout     = dout_q;
   assign bus.rd_valid = rd_valid_q;
`endif
   assign bus.busy = busy;
endmodule

// File: tb/tb_spram_modes.sv
// tb_spram_modes: three spram_modes instances (write-first, read-first, no-change) on shared
// stimulus, checked against constants and a word-level reference model.
module tb_spram_modes;
   import spram_pkg::*;
   localparam int          DW    = 32;
   localparam int          AW    = 5;
   localparam int          NB    = 4;
   localparam int          DEPTH = 32;
   localparam logic [31:0] CV    = 32'hC1EA_5A5A;
`ifdef SPRAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0, we = 1'b0, clr = 1'b0;
   logic [NB-1:0] be = '0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] got_d [3];
   logic          got_v [3];
   logic          got_b [3];
   int            n_cmp = 0, n_fail = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      spram_modes_if #(.DATA_W(DW), .BYTE_W(8), .ADDR_W(AW)) bus ();
      assign bus.en   = en;
      assign bus.we   = we;
      assign bus.be   = be;
      assign bus.addr = addr;
      assign bus.din  = din;
      assign bus.clr  = clr;
      assign got_d[g] = bus.dout;
      assign got_v[g] = bus.rd_valid;
      assign got_b[g] = bus.busy;
      spram_modes #(.DATA_W(DW), .BYTE_W(8), .ADDR_W(AW), .MODE(rw_mode_e'(g)), .CLEAR_VAL(CV)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end
   // Reference: word array, countdown of remaining clear writes, per-mode output stages.
   logic [DW-1:0] m_mem [DEPTH];
   int            clr_left = 0;
   logic [DW-1:0] md [3], pd [3], ed [3];
   logic          mv [3], pv [3], ev [3];
   always @(posedge clk) begin
      logic [DW-1:0] o, n;
      if (rst) begin
         clr_left = DEPTH;
         for (int m = 0; m < 3; m++) begin md[m] = '0; mv[m] = 0; pd[m] = '0; pv[m] = 0; end
      end else begin
         for (int m = 0; m < 3; m++) begin pd[m] = md[m]; pv[m] = mv[m]; mv[m] = 0; end
         if (clr_left > 0) begin
            m_mem[DEPTH-clr_left] = CV;
            clr_left--;
         end else if (clr) clr_left = DEPTH;
         else if (en) begin
            o = m_mem[addr];
            n = o;
            for (int b = 0; b < NB; b++) if (we && be[b]) n[b*8 +: 8] = din[b*8 +: 8];
            m_mem[addr] = n;
            md[0] = n; mv[0] = 1;
            md[1] = o; mv[1] = 1;
            if (!(we && be != 0)) begin md[2] = o; mv[2] = 1; end
         end
      end
      for (int m = 0; m < 3; m++) begin
         ed[m] = (LAT == 2) ? pd[m] : md[m];
         ev[m] = (LAT == 2) ? pv[m] : mv[m];
      end
   end
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic drive(input logic e, input logic w, input logic [NB-1:0] b,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      en = e; we = w; be = b; addr = a; din = d;
   endtask
   task automatic test_reset();
      int cnt;
      rst = 1;
      repeat (3) begin
         tick();
         for (int m = 0; m < 3; m++) begin
            n_cmp++;
            if (got_b[m] !== 1'b1 || got_d[m] !== '0 || got_v[m] !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_hold m%0d: busy=%b dout=%h rv=%b, want busy=1 dout=0 rv=0", m, got_b[m], got_d[m], got_v[m]);
            end
         end
      end
      rst = 0;
      cnt = 0;
      while (got_b[0] && cnt < 100) begin tick(); cnt++; end
      n_cmp++;
      if (cnt !== DEPTH) begin
         n_fail++;
         $display("FAIL reset_busy_len: got %0d cycles, want %0d", cnt, DEPTH);
      end
      for (int a = 0; a < DEPTH; a++) begin
         drive(1, 0, '0, AW'(a), '0);
         tick();
         drive(0, 0, '0, '0, '0);
         repeat (LAT - 1) tick();
         for (int m = 0; m < 3; m++) begin
            n_cmp++;
            if (got_d[m] !== CV || got_v[m] !== 1'b1) begin
               n_fail++;
               $display("FAIL reset_contents m%0d a%0d: dout=%h rv=%b, want %h rv=1", m, a, got_d[m], got_v[m], CV);
            end
         end
      end
   endtask
   task automatic test_write_modes();
      logic [DW-1:0] want [3];
      logic          wv [3];
      drive(1, 1, 4'hF, 5'd3, 32'h1122_3344);
      tick();
      drive(1, 1, 4'b0101, 5'd3, 32'hAABB_CCDD);
      tick();
      drive(0, 0, '0, '0, '0);
      repeat (LAT - 1) tick();
      want = '{32'h11BB_33DD, 32'h1122_3344, CV};
      wv   = '{1'b1, 1'b1, 1'b0};
      for (int m = 0; m < 3; m++) begin
         n_cmp++;
         if (got_d[m] !== want[m] || got_v[m] !== wv[m]) begin
            n_fail++;
            $display("FAIL byte_write m%0d: dout=%h rv=%b, want %h rv=%b", m, got_d[m], got_v[m], want[m], wv[m]);
         end
      end
      drive(1, 0, '0, 5'd3, '0);
      tick();
      drive(0, 0, '0, '0, '0);
      repeat (LAT - 1) tick();
      for (int m = 0; m < 3; m++) begin
         n_cmp++;
         if (got_d[m] !== 32'h11BB_33DD || got_v[m] !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_readback m%0d: dout=%h rv=%b, want 11bb33dd rv=1", m, got_d[m], got_v[m]);
         end
      end
   endtask
   task automatic test_no_change();
      logic [DW-1:0] want [3];
      drive(1, 1, 4'hF, 5'd1, 32'h5);
      tick();
      drive(1, 0, '0, 5'd1, '0);
      tick();
      drive(0, 0, '0, '0, '0);
      repeat (LAT - 1) tick();
      n_cmp++;
      if (got_d[2] !== 32'h5 || got_v[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL nc_read: dout=%h rv=%b, want 5 rv=1", got_d[2], got_v[2]);
      end
      drive(1, 1, 4'hF, 5'd1, 32'h77);
      tick();
      drive(0, 0, '0, '0, '0);
      repeat (LAT - 1) tick();
      want = '{32'h77, 32'h5, 32'h5};
      for (int m = 0; m < 3; m++) begin
         n_cmp++;
         if (got_d[m] !== want[m] || got_v[m] !== (m != 2)) begin
            n_fail++;
            $display("FAIL nc_write m%0d: dout=%h rv=%b, want %h rv=%b", m, got_d[m], got_v[m], want[m], m != 2);
         end
      end
   endtask
   task automatic test_clear();
      int cnt;
      en = 1; we = 1; be = 4'hF; addr = 5'd2; din = 32'h1234_5678; clr = 1;
      tick();
      drive(0, 0, '0, '0, '0);
      clr = 0;
      cnt = 0;
      while (got_b[0] && cnt < 100) begin clr = (cnt == 10); tick(); cnt++; end
      clr = 0;
      n_cmp++;
      if (cnt !== DEPTH) begin
         n_fail++;
         $display("FAIL clr_busy_len: got %0d cycles, want %0d", cnt, DEPTH);
      end
      for (int a = 1; a < 4; a++) begin
         drive(1, 0, '0, AW'(a), '0);
         tick();
         drive(0, 0, '0, '0, '0);
         repeat (LAT - 1) tick();
         n_cmp++;
         if (got_d[1] !== CV) begin
            n_fail++;
            $display("FAIL clr_contents a%0d: dout=%h, want %h", a, got_d[1], CV);
         end
      end
      clr = 1;
      tick();
      clr = 0;
      repeat (10) tick();
      rst = 1;
      tick();
      rst = 0;
      cnt = 0;
      while (got_b[0] && cnt < 100) begin tick(); cnt++; end
      n_cmp++;
      if (cnt !== DEPTH) begin
         n_fail++;
         $display("FAIL rst_restart_len: got %0d cycles, want %0d", cnt, DEPTH);
      end
   endtask
   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, NB'($urandom),
               AW'($urandom_range(0, 7)), $urandom);
         clr = $urandom_range(0, 99) == 0;
         tick();
         for (int m = 0; m < 3; m++) begin
            n_cmp++;
            if (got_d[m] !== ed[m] || got_v[m] !== ev[m] || got_b[m] !== (clr_left > 0)) begin
               n_fail++;
               $display("FAIL random k%0d m%0d: dout=%h rv=%b busy=%b, want %h rv=%b busy=%b",
                        k, m, got_d[m], got_v[m], got_b[m], ed[m], ev[m], clr_left > 0);
            end
         end
      end
      clr = 0;
      drive(0, 0, '0, '0, '0);
   endtask
   initial begin
      test_reset();
      test_write_modes();
      test_no_change();
      test_clear();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/spram_modes.md
# spram_modes

Parametrised single-port synchronous RAM, the next generation of the team's write-first single-port RAM. Adds configurable width and depth, per-byte write enables, a compile-time read-during-write mode (write-first, read-first, no-change) and a hardware clear engine that initialises every word after reset or on request. Used as the general-purpose local buffer in datapath blocks that need deterministic memory contents after reset.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be a multiple of BYTE_W
- BYTE_W, 8, byte-lane width; NB = DATA_W/BYTE_W lanes
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words
- MODE, MODE_WRITE_FIRST, read-during-write behaviour (spram_pkg::rw_mode_e)
- CLEAR_VAL, '0, word written to every address by the clear engine

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- en  in  1  access enable
- we  in  1  write enable, qualified by en
- be  in  NB  byte-lane write enables, qualified by en & we
- addr  in  ADDR_W  word address
- din  in  DATA_W  write data
- clr  in  1  single-cycle clear request
- dout  out  DATA_W  registered read data
- rd_valid  out  1  dout updated this cycle by an accepted access
- busy  out  1  clear engine active; accesses ignored

## Operation
- Access accepted when en=1 and busy=0; otherwise dropped, no memory change, dout held.
- Write: lanes with be[i]=1 take din lane i; other lanes keep old value. we=1 with be=0 is a read with no memory change.
- Read/dout update on every accepted access (we=0 or we=1):
  - MODE_WRITE_FIRST: dout = merged new word.
  - MODE_READ_FIRST: dout = word before the write.
  - MODE_NO_CHANGE: dout updates on reads only; on write dout holds, rd_valid=0.
- rd_valid=1 the cycle after any accepted access that updated dout; 0 otherwise.
- Clear FSM, states IDLE and CLEAR, counter clr_addr (ADDR_W bits):
  - rst=1: state CLEAR, clr_addr=0, busy=1, dout=0, rd_valid=0; no memory writes while rst held.
  - CLEAR (rst=0): write CLEAR_VAL to mem[clr_addr], increment; after writing DEPTH-1 go IDLE. Takes exactly DEPTH cycles.
  - IDLE and clr=1: go CLEAR, clr_addr=0; any same-cycle en access dropped (clr wins).
  - clr during CLEAR: ignored, no restart.
  - rst mid-clear: restart from address 0.
- dout holds last value during CLEAR (0 after rst).

## Timing
- Read latency 1 cycle (2 with SPRAM_OUTREG_EN): addr/en sampled at edge N, dout/rd_valid valid after edge N.
- busy rises the cycle after clr accepted; after rst, busy=1 throughout rst and DEPTH cycles following deassertion.
- First accepted access: cycle busy reads 0.
- Back-to-back accesses at full rate, one per cycle; no bubbles.

## Configuration
- SPRAM_OUTREG_EN defined: extra pipeline register on dout and rd_valid; latency 2; both reset to 0; stage still advances while busy (drains).
- Undefined: single registered output stage, latency 1.

## Structure
- spram_pkg: rw_mode_e (MODE_WRITE_FIRST, MODE_READ_FIRST, MODE_NO_CHANGE), clear FSM state enum.
- Sub-module spram_clear_fsm: state, clr_addr counter, busy; outputs write strobe/address/data muxed onto the array port in spram_modes.
- Array, byte-merge, mode mux and output register(s) stay in spram_modes.

## Test plan
- Reset: rst 3 cycles, ADDR_W=5 -> busy=1 for rst plus 32 cycles, dout=0; reading all addresses returns CLEAR_VAL.
- WRITE_FIRST: mem[3]=0x11223344, write din=0xAABBCCDD be=4'b0101 addr 3 -> dout=0x11BB33DD next cycle, rd_valid=1.
- READ_FIRST same stimulus -> dout=0x11223344; following read of addr 3 -> 0x11BB33DD.
- NO_CHANGE: read addr 1 (0x5) then write addr 1 -> dout holds 0x5, rd_valid=0 on write cycle.
- clr with en write same cycle -> write dropped, busy high 32 cycles, clr re-pulsed mid-clear ignored; rst at cycle 10 of clear restarts full clear.
- SPRAM_OUTREG_EN: read addr 7 at edge N -> dout/rd_valid after edge N+1.
